// File: rtl/mem_access.sv
// Memory-access pipeline stage: sizes/aligns loads and stores, runs the data-memory
// req/ack handshake, stalls while a transfer is in flight and extends load results.
module mem_access (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [31:0] alu_res,
    input  logic [31:0] store_data,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  mem_size,
    input  logic        mem_unsigned,
    output logic        stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        misalign
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  off_q, off_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [31:0] load_data_q, load_data_d;
    logic        load_valid_q, load_valid_d;

    logic        is_req;
    logic        misaligned;
    logic        aligned_req;
    logic [3:0]  be_calc;
    logic [31:0] wdata_calc;
    logic [31:0] rshift;
    logic [31:0] load_ext;

    assign is_req      = in_valid & (mem_read | mem_write);
    assign aligned_req = is_req & ~misaligned;

    always_comb begin
        misaligned = 1'b0;
        be_calc    = 4'b1111;
        wdata_calc = store_data;
        case (mem_size)
            2'b00: begin
                be_calc    = 4'b0001 << alu_res[1:0];
                wdata_calc = {4{store_data[7:0]}};
            end
            2'b01: begin
                misaligned = alu_res[0];
                be_calc    = 4'b0011 << {alu_res[1], 1'b0};
                wdata_calc = {2{store_data[15:0]}};
            end
            default: begin
                misaligned = |alu_res[1:0];
            end
        endcase
    end

    // Extraction uses the latched offset/size: the EX/MEM inputs may not be trusted at ack time.
    always_comb begin
        rshift = dmem_rdata >> {off_q, 3'b000};
        case (size_q)
            2'b00:   load_ext = uns_q ? {24'd0, rshift[7:0]}  : {{24{rshift[7]}}, rshift[7:0]};
            2'b01:   load_ext = uns_q ? {16'd0, rshift[15:0]} : {{16{rshift[15]}}, rshift[15:0]};
            default: load_ext = dmem_rdata;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        we_d         = we_q;
        addr_d       = addr_q;
        be_d         = be_q;
        wdata_d      = wdata_q;
        off_d        = off_q;
        size_d       = size_q;
        uns_d        = uns_q;
        load_data_d  = load_data_q;
        load_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (aligned_req) begin
                    req_d   = 1'b1;
                    we_d    = mem_write;
                    addr_d  = {alu_res[31:2], 2'b00};
                    be_d    = be_calc;
                    wdata_d = wdata_calc;
                    off_d   = alu_res[1:0];
                    size_d  = mem_size;
                    uns_d   = mem_unsigned;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (dmem_ack) begin
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    state_d = DONE;
                    if (!we_q) begin
                        load_data_d  = load_ext;
                        load_valid_d = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
                we_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            req_q        <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= 32'd0;
            be_q         <= 4'd0;
            wdata_q      <= 32'd0;
            off_q        <= 2'd0;
            size_q       <= 2'd0;
            uns_q        <= 1'b0;
            load_data_q  <= 32'd0;
            load_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            be_q         <= be_d;
            wdata_q      <= wdata_d;
            off_q        <= off_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            load_data_q  <= load_data_d;
            load_valid_q <= load_valid_d;
        end
    end

    assign stall      = ((state_q == IDLE) & aligned_req) | (state_q == BUSY);
    assign misalign   = (state_q == IDLE) & is_req & misaligned;
    assign dmem_req   = req_q;
    assign dmem_we    = we_q & req_q;
    assign dmem_addr  = addr_q;
    assign dmem_be    = be_q;
    assign dmem_wdata = wdata_q;
    assign load_data  = load_data_q;
    assign load_valid = load_valid_q;

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: vector table plus hand-written reset sequences.
module tb_mem_access;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] alu_res = 32'd0;
    logic [31:0] store_data = 32'd0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [1:0]  mem_size = 2'd0;
    logic        mem_unsigned = 1'b0;
    logic        stall;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack = 1'b0;
    logic [31:0] dmem_rdata = 32'd0;
    logic [31:0] load_data;
    logic        load_valid;
    logic        misalign;

    always #5 clk = ~clk;

    mem_access dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .alu_res      (alu_res),
        .store_data   (store_data),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_size     (mem_size),
        .mem_unsigned (mem_unsigned),
        .stall        (stall),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_be      (dmem_be),
        .dmem_wdata   (dmem_wdata),
        .dmem_ack     (dmem_ack),
        .dmem_rdata   (dmem_rdata),
        .load_data    (load_data),
        .load_valid   (load_valid),
        .misalign     (misalign)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] sd;
        logic        rd;
        logic        wr;
        logic [1:0]  size;
        logic        uns;
        int          waits;
        logic [31:0] rdata;
        logic        mis;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] ld;
    } vec_t;

    localparam int NV = 14;
    vec_t        vecs[NV];
    int          n_tests = 0;
    int          n_fail = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_load = 32'd0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic run_vec(input int i);
        vec_t v;
        int   stall_cnt;
        int   req_cnt;
        bit   is_load;
        v         = vecs[i];
        stall_cnt = 0;
        req_cnt   = 0;
        is_load   = v.rd && !v.wr;
        @(negedge clk);
        in_valid     = 1'b1;
        alu_res      = v.addr;
        store_data   = v.sd;
        mem_read     = v.rd;
        mem_write    = v.wr;
        mem_size     = v.size;
        mem_unsigned = v.uns;
        #1;
        chk("misalign", {31'd0, misalign}, {31'd0, v.mis});
        if (v.mis) begin
            chk("mis_stall", {31'd0, stall}, 32'd0);
            @(negedge clk);
            chk("mis_noreq", {31'd0, dmem_req}, 32'd0);
            chk("mis_pulse", {31'd0, misalign}, 32'd1);
            in_valid = 1'b0;
            #1;
            chk("mis_clear", {31'd0, misalign}, 32'd0);
            $display("[TB] vec %0d addr=%h misaligned access rejected", i, v.addr);
            return;
        end
        if (stall) stall_cnt++;
        if (is_load) exp_q.push_back(v.ld);
        @(negedge clk);
        chk("addr", dmem_addr, {v.addr[31:2], 2'b00});
        chk("be", {28'd0, dmem_be}, {28'd0, v.be});
        chk("we", {31'd0, dmem_we}, {31'd0, v.wr});
        if (v.wr) chk("wdata", dmem_wdata, v.wdata);
        for (int w = 0; w <= v.waits; w++) begin
            if (w > 0) @(negedge clk);
            if (stall) stall_cnt++;
            if (dmem_req) req_cnt++;
            if (w == v.waits) begin
                dmem_ack   = 1'b1;
                dmem_rdata = v.rdata;
            end else begin
                dmem_rdata = $urandom;
            end
        end
        @(negedge clk);
        dmem_ack   = 1'b0;
        dmem_rdata = $urandom;
        chk("stall_cycles", stall_cnt, v.waits + 2);
        chk("req_cycles", req_cnt, v.waits + 1);
        chk("done_stall", {31'd0, stall}, 32'd0);
        chk("done_req", {31'd0, dmem_req}, 32'd0);
        chk("load_valid", {31'd0, load_valid}, {31'd0, is_load});
        if (load_valid) begin
            if (exp_q.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
            else chk("load_data", load_data, exp_q.pop_front());
        end
        if (is_load) last_load = v.ld;
        else chk("load_hold", load_data, last_load);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("lv_pulse", {31'd0, load_valid}, 32'd0);
        $display("[TB] vec %0d addr=%h %s size=%0d waits=%0d load_data=%h", i, v.addr,
                 v.wr ? "store" : "load", v.size, v.waits, load_data);
    endtask

    initial begin
        vecs[0]  = '{32'h100, 32'h0,        1'b1, 1'b0, 2'd2, 1'b0, 3, 32'hDEADBEEF, 1'b0, 4'hF, 32'h0,        32'hDEADBEEF};
        vecs[1]  = '{32'h103, 32'h0,        1'b1, 1'b0, 2'd0, 1'b0, 0, 32'h80123456, 1'b0, 4'h8, 32'h0,        32'hFFFFFF80};
        vecs[2]  = '{32'h103, 32'h0,        1'b1, 1'b0, 2'd0, 1'b1, 1, 32'h80123456, 1'b0, 4'h8, 32'h0,        32'h00000080};
        vecs[3]  = '{32'h202, 32'h0000ABCD, 1'b0, 1'b1, 2'd1, 1'b0, 0, 32'h0,        1'b0, 4'hC, 32'hABCDABCD, 32'h0};
        vecs[4]  = '{32'h101, 32'h0,        1'b1, 1'b0, 2'd2, 1'b0, 0, 32'h0,        1'b1, 4'h0, 32'h0,        32'h0};
        vecs[5]  = '{32'h205, 32'h0,        1'b1, 1'b0, 2'd1, 1'b0, 0, 32'h0,        1'b1, 4'h0, 32'h0,        32'h0};
        vecs[6]  = '{32'h300, 32'h12345678, 1'b1, 1'b1, 2'd2, 1'b0, 1, 32'h0,        1'b0, 4'hF, 32'h12345678, 32'h0};
        vecs[7]  = '{32'h102, 32'h0,        1'b1, 1'b0, 2'd1, 1'b0, 2, 32'h80017FFF, 1'b0, 4'hC, 32'h0,        32'hFFFF8001};
        vecs[8]  = '{32'h206, 32'h0,        1'b1, 1'b0, 2'd1, 1'b1, 0, 32'hFEDC0000, 1'b0, 4'hC, 32'h0,        32'h0000FEDC};
        vecs[9]  = '{32'h101, 32'h0,        1'b1, 1'b0, 2'd0, 1'b0, 1, 32'h1122F344, 1'b0, 4'h2, 32'h0,        32'hFFFFFFF3};
        vecs[10] = '{32'h001, 32'h0000AA55, 1'b0, 1'b1, 2'd0, 1'b0, 0, 32'h0,        1'b0, 4'h2, 32'h55555555, 32'h0};
        vecs[11] = '{32'h104, 32'h0,        1'b1, 1'b0, 2'd3, 1'b0, 0, 32'h0BADF00D, 1'b0, 4'hF, 32'h0,        32'h0BADF00D};
        vecs[12] = '{32'h100, 32'h0,        1'b1, 1'b0, 2'd1, 1'b0, 0, 32'h12348765, 1'b0, 4'h3, 32'h0,        32'hFFFF8765};
        vecs[13] = '{32'h302, 32'h0,        1'b0, 1'b1, 2'd3, 1'b0, 0, 32'h0,        1'b1, 4'h0, 32'h0,        32'h0};

        // Reset values, both during and right after reset
        repeat (2) @(negedge clk);
        chk("rst_req", {31'd0, dmem_req}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rst_addr", dmem_addr, 32'd0);
        chk("rst_wdata", dmem_wdata, 32'd0);
        chk("rst_be_we", {27'd0, dmem_be, dmem_we}, 32'd0);
        chk("rst_load", load_data, 32'd0);
        chk("rst_flags", {29'd0, load_valid, misalign, stall}, 32'd0);
        $display("[TB] reset state checked");

        // Non-memory instruction passes without stall; ack in IDLE is ignored
        @(negedge clk);
        in_valid = 1'b1;
        mem_read = 1'b0;
        mem_write = 1'b0;
        dmem_ack = 1'b1;
        #1;
        chk("nonmem_stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        chk("idle_ack_req", {31'd0, dmem_req}, 32'd0);
        chk("idle_ack_lv", {31'd0, load_valid}, 32'd0);
        dmem_ack = 1'b0;
        in_valid = 1'b0;
        $display("[TB] non-memory instruction and idle ack checked");

        for (int i = 0; i < NV; i++) run_vec(i);

        // Reset while BUSY, then a stray ack
        @(negedge clk);
        in_valid = 1'b1;
        alu_res = 32'h400;
        mem_read = 1'b1;
        mem_write = 1'b0;
        mem_size = 2'd2;
        mem_unsigned = 1'b0;
        @(negedge clk);
        chk("busy_req", {31'd0, dmem_req}, 32'd1);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_drop", {31'd0, dmem_req}, 32'd0);
        chk("async_stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dmem_ack = 1'b1;
        dmem_rdata = 32'hCAFEF00D;
        @(negedge clk);
        dmem_ack = 1'b0;
        chk("stray_lv", {31'd0, load_valid}, 32'd0);
        chk("stray_req", {31'd0, dmem_req}, 32'd0);
        chk("stray_load", load_data, 32'd0);
        last_load = 32'd0;
        $display("[TB] reset during BUSY and stray ack checked");

        run_vec(0);
        run_vec(3);
        chk("sb_empty", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
